// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arith ops and an iterative shift-add multiplier
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic [W-1:0] rslt,
    output logic         zero,
    output logic         carry,
    output logic         err,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, MULT} state_t;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] W_V = W'(W);
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mcand;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_nxt;
    logic [W:0]     sum;
    logic           mulh;
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_rslt;
    logic [W:0]     add_w;
    logic [W-1:0]   s_rslt;
    logic           s_carry;
    logic           s_err;
    logic           is_mul;
    logic           last;
    // single-cycle result straight from the live operands, used only on the accepting edge
    always_comb begin
        add_w   = {1'b0, inA} + {1'b0, inB};
        s_rslt  = '0;
        s_carry = 1'b0;
        s_err   = 1'b0;
        case (alu_cmd)
            4'b0000: s_rslt = inA & inB;
            4'b0001: begin
                s_rslt  = add_w[W-1:0];
                s_carry = add_w[W];
            end
            4'b0010: s_rslt = inA ^ inB;
            4'b0011: s_rslt = W'(inA != inB);
            4'b0100: s_rslt = (inB >= W_V) ? '0 : inA << inB;
            4'b0101: s_rslt = (inB >= W_V) ? '0 : inA >> inB;
            4'b0110: begin
                s_rslt  = inA - inB;
                s_carry = inA >= inB;
            end
            4'b0111: s_rslt = inA | inB;
            4'b1000, 4'b1001: s_rslt = '0;
            default: s_err = 1'b1;
        endcase
    end
    // one shift-add step: low half holds the remaining multiplier bits, high half the partial sum
    always_comb begin
        is_mul   = alu_cmd[3:1] == 3'b100;
        last     = cnt == CW'(W - 1);
        sum      = {1'b0, prod[2*W-1:W]} + {1'b0, mcand & {W{prod[0]}}};
        prod_nxt = {sum, prod[W-1:1]};
        m_hi     = prod_nxt[2*W-1:W];
        m_rslt   = mulh ? m_hi : prod_nxt[W-1:0];
    end
    // control FSM with registered result, flags, busy and done
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
            mulh  <= 1'b0;
            rslt  <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_mul) begin
                        state <= MULT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        prod  <= {{W{1'b0}}, inB};
                        mcand <= inA;
                        mulh  <= alu_cmd[0];
                    end else if (start) begin
                        rslt  <= s_rslt;
                        zero  <= s_rslt == '0;
                        carry <= s_carry;
                        err   <= s_err;
                        done  <= 1'b1;
                    end
                end
                MULT: begin
                    prod <= prod_nxt;
                    cnt  <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rslt  <= m_rslt;
                        zero  <= m_rslt == '0;
                        carry <= |m_hi;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at W=8
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] alu_cmd = 4'b0000;
    logic [7:0] inA = 8'h00;
    logic [7:0] inB = 8'h00;
    logic [7:0] rslt;
    logic       zero;
    logic       carry;
    logic       err;
    logic       busy;
    logic       done;
    int         n_chk = 0;
    int         n_fail = 0;
    alu_seq #(.W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .alu_cmd(alu_cmd),
        .inA(inA),
        .inB(inB),
        .rslt(rslt),
        .zero(zero),
        .carry(carry),
        .err(err),
        .busy(busy),
        .done(done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic sop(input string tag, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ez, input logic ec, input logic ee);
        @(negedge clk);
        start = 1'b1;
        alu_cmd = cmd;
        inA = a;
        inB = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".rslt"}, rslt, er);
        check({tag, ".zero"}, zero, ez);
        check({tag, ".carry"}, carry, ec);
        check({tag, ".err"}, err, ee);
    endtask
    task automatic mul_op(input string tag, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          input bit inj, input logic [7:0] er, input logic ez, input logic ec);
        int nb;
        int nd;
        int at;
        logic [7:0] r;
        logic z;
        logic c;
        logic e;
        nb = 0;
        nd = 0;
        at = -1;
        r = 'x;
        z = 'x;
        c = 'x;
        e = 'x;
        @(negedge clk);
        start = 1'b1;
        alu_cmd = cmd;
        inA = a;
        inB = b;
        @(posedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (inj && i == 2) begin
                start = 1'b1;
                alu_cmd = 4'b0001;
                inA = 8'hFF;
                inB = 8'hFF;
            end
            if (inj && i == 3) start = 1'b0;
            if (busy) nb++;
            if (done) begin
                nd++;
                if (at < 0) at = i;
                r = rslt;
                z = zero;
                c = carry;
                e = err;
            end
        end
        check({tag, ".busy_cycles"}, nb, 8);
        check({tag, ".done_count"}, nd, 1);
        check({tag, ".done_at"}, at, 8);
        check({tag, ".rslt"}, r, er);
        check({tag, ".zero"}, z, ez);
        check({tag, ".carry"}, c, ec);
        check({tag, ".err"}, e, 0);
        check({tag, ".hold"}, rslt, er);
    endtask
    initial begin
        int nd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.rslt", rslt, 0);
        check("rst.flags", {zero, carry, err, busy, done}, 0);
        reset = 1'b0;
        sop("add", 4'b0001, 8'hF0, 8'h20, 8'h10, 0, 1, 0);
        @(negedge clk);
        check("add.done_drop", done, 0);
        check("add.hold", rslt, 8'h10);
        sop("and", 4'b0000, 8'hCA, 8'h0F, 8'h0A, 0, 0, 0);
        sop("xor", 4'b0010, 8'hAA, 8'hFF, 8'h55, 0, 0, 0);
        sop("ne_eq", 4'b0011, 8'h05, 8'h05, 8'h00, 1, 0, 0);
        sop("ne_ne", 4'b0011, 8'h05, 8'h06, 8'h01, 0, 0, 0);
        sop("ls9", 4'b0100, 8'h81, 8'h09, 8'h00, 1, 0, 0);
        sop("ls1", 4'b0100, 8'h81, 8'h01, 8'h02, 0, 0, 0);
        sop("ls7", 4'b0100, 8'h01, 8'h07, 8'h80, 0, 0, 0);
        sop("rs7", 4'b0101, 8'h81, 8'h07, 8'h01, 0, 0, 0);
        sop("rs8", 4'b0101, 8'h81, 8'h08, 8'h00, 1, 0, 0);
        sop("sub_b", 4'b0110, 8'h05, 8'h07, 8'hFE, 0, 0, 0);
        sop("sub_nb", 4'b0110, 8'h07, 8'h05, 8'h02, 0, 1, 0);
        sop("sub_eq", 4'b0110, 8'h33, 8'h33, 8'h00, 1, 1, 0);
        sop("or", 4'b0111, 8'hA0, 8'h05, 8'hA5, 0, 0, 0);
        sop("add_z", 4'b0001, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
        sop("ill_f", 4'b1111, 8'h12, 8'h34, 8'h00, 1, 0, 1);
        mul_op("mul", 4'b1000, 8'h10, 8'h10, 0, 8'h00, 1, 1);
        mul_op("mulh", 4'b1001, 8'h10, 8'h10, 0, 8'h01, 0, 1);
        mul_op("mul_ign", 4'b1000, 8'h0F, 8'h11, 1, 8'hFF, 0, 0);
        mul_op("mulh_ff", 4'b1001, 8'hFF, 8'hFF, 0, 8'hFE, 0, 1);
        mul_op("mul_ff", 4'b1000, 8'hFF, 8'hFF, 1, 8'h01, 0, 1);
        @(negedge clk);
        start = 1'b1;
        alu_cmd = 4'b1100;
        inA = 8'h55;
        inB = 8'h66;
        @(posedge clk);
        @(negedge clk);
        check("b2b_ill.done", done, 1);
        check("b2b_ill.rslt", rslt, 0);
        check("b2b_ill.zf", {zero, err, carry}, 3'b110);
        alu_cmd = 4'b0000;
        inA = 8'hF0;
        inB = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_and.done", done, 1);
        check("b2b_and.rslt", rslt, 8'h30);
        check("b2b_and.zf", {zero, err, carry}, 3'b000);
        @(negedge clk);
        check("b2b.done_drop", done, 0);
        start = 1'b1;
        alu_cmd = 4'b1000;
        inA = 8'hFF;
        inB = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort.busy_pre", busy, 1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.rslt", rslt, 0);
        check("abort.flags", {zero, carry, err}, 0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort.no_done", nd, 0);
        check("abort.rslt_hold", rslt, 0);
        sop("pre_rst", 4'b0111, 8'h0F, 8'h30, 8'h3F, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        alu_cmd = 4'b0001;
        inA = 8'hF0;
        inB = 8'h20;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_prio.done", done, 0);
        check("rst_prio.rslt", rslt, 0);
        check("rst_prio.carry", carry, 0);
        @(negedge clk);
        check("rst_prio.drop", done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the data path width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port alu_cmd, input, 4 bits: opcode, sampled with start.
REQ-006 The block SHALL have ports inA and inB, inputs, W bits each: operands, sampled with start.
REQ-007 The block SHALL have port rslt, output, W bits: registered result.
REQ-008 The block SHALL have ports zero, carry and err, outputs, 1 bit each: registered flags.
REQ-009 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new rslt/flags value.

Function
REQ-011 start SHALL be accepted on a rising edge where start=1 and busy=0; start while busy=1 SHALL be ignored, with no queuing.
REQ-012 alu_cmd, inA and inB SHALL be captured at acceptance; later changes SHALL NOT affect the operation in progress.
REQ-013 Opcodes SHALL be: 0000 AND, 0001 ADD, 0010 XOR, 0011 NE (rslt=1 if inA!=inB else 0), 0100 LS (inA<<inB), 0101 RS (logical inA>>inB), 0110 SUB (inA-inB), 0111 OR, 1000 MUL (low W bits of inA*inB), 1001 MULH (high W bits of the unsigned product).
REQ-014 LS and RS with inB >= W SHALL give rslt=0.
REQ-015 All arithmetic SHALL be unsigned, modulo 2^W.
REQ-016 carry SHALL be: ADD carry-out; SUB 1 when inA >= inB (no borrow); MUL/MULH 1 when the high half of the product is nonzero; 0 for all other opcodes.
REQ-017 zero SHALL be 1 exactly when the new rslt equals 0.
REQ-018 Opcodes 1010-1111 SHALL complete as single-cycle ops with rslt=0, zero=1, carry=0, err=1; err SHALL be 0 for every legal opcode.
REQ-019 Single-cycle opcodes (0000-0111 and illegal) SHALL load rslt/flags on the accepting edge, pulse done for the following cycle, and leave busy at 0.
REQ-020 MUL/MULH SHALL use an iterative shift-add engine, one multiplier bit per cycle, with FSM states IDLE -> MULT -> IDLE.
REQ-021 On accepting a MUL/MULH, the FSM SHALL enter MULT with busy=1 for exactly W cycles, and the iteration counter SHALL run 0..W-1.
REQ-022 On the edge that ends the last iteration, the FSM SHALL return to IDLE, load rslt/flags, set busy=0, and pulse done for one cycle.
REQ-023 rslt and flags SHALL hold their values between done pulses.
REQ-024 start SHALL be acceptable in the same cycle done is high, so back-to-back single-cycle ops give done on every cycle.
REQ-025 done SHALL never be high for more than one cycle per accepted operation.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL go to IDLE and set rslt=0, zero=0, carry=0, err=0, busy=0, done=0, and counter=0.
REQ-027 Reset SHALL take priority over start on the same edge, and the start SHALL be dropped.
REQ-028 Reset during MULT SHALL abort the operation with no done pulse, and the aborted result SHALL never appear on rslt.

Verification
REQ-029 W=8, ADD 0xF0+0x20 -> one cycle after acceptance: done=1, rslt=0x10, carry=1, zero=0, busy stays 0.
REQ-030 W=8, MUL 0x10*0x10 -> busy=1 for 8 cycles, then done=1, rslt=0x00, zero=1, carry=1; MULH with the same operands -> rslt=0x01, carry=1.
REQ-031 W=8, MUL 0x0F*0x11 -> rslt=0xFF, carry=0; start with ADD asserted during busy -> ignored, exactly one done pulse.
REQ-032 W=8, LS 0x81 by 9 -> rslt=0x00, zero=1; RS 0x81 by 7 -> rslt=0x01; SUB 0x05-0x07 -> rslt=0xFE, carry=0.
REQ-033 Reset asserted on the 4th cycle of a MUL -> next cycle busy=0, done=0, rslt=0, and no done follows.
REQ-034 alu_cmd=1100 -> rslt=0, zero=1, err=1; a following AND 0xF0&0x3C -> rslt=0x30, err=0, with done high on both consecutive cycles.
